// File: rtl/sr_bank_scheduler_if.sv
// Requester-side command bus of sr_bank_scheduler: per-requester valid/op/idx
// with a one-hot ready strobe returned by the scheduler.
interface sr_bank_scheduler_if #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 3
) ();
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_op;
  logic [N_REQ*IDX_W-1:0] req_idx;
  logic [N_REQ-1:0]       req_ready;

  modport master (
    output req_valid,
    output req_op,
    output req_idx,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_op,
    input  req_idx,
    output req_ready
  );
endinterface

// File: rtl/sr_bank_scheduler.sv
// Round-robin sequencer of one-hot set/reset pulses onto a bank of SR flip-flops.
// Define SR_SCHED_NOP_FILTER_EN to skip commands that would not change q_shadow.
module sr_bank_scheduler #(
  parameter int N_REQ     = 4,
  parameter int N_BITS    = 8,
  parameter int IDX_W     = 3,
  parameter int PULSE_CYC = 1
) (
  input  logic              clk,
  input  logic              rst,
  sr_bank_scheduler_if.slave req,
  output logic [N_BITS-1:0] s_out,
  output logic [N_BITS-1:0] r_out,
  output logic [N_BITS-1:0] q_shadow,
  output logic              busy,
  output logic              err_idx
);
  localparam int PTR_W = $clog2(N_REQ);
  localparam int CNT_W = (PULSE_CYC > 1) ? $clog2(PULSE_CYC) : 1;

  typedef enum logic {IDLE, DRIVE} state_t;

  state_t             state;
  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   nxt_q;
  logic [CNT_W-1:0]   cnt;
  logic               op_q;
  logic [N_BITS-1:0]  mask_q;

  logic [PTR_W-1:0]   win;
  logic [PTR_W-1:0]   win_next;
  logic               win_found;
  logic               win_op;
  logic [IDX_W-1:0]   win_idx;
  logic [N_BITS-1:0]  win_mask;
  logic               win_oob;
  logic               win_nop;
  int unsigned        k;

  // First valid requester at or after ptr, wrapping modulo N_REQ.
  always_comb begin
    win       = '0;
    win_found = 1'b0;
    k         = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      k = 32'(ptr) + i;
      if (k >= N_REQ) k = k - N_REQ;
      if (!win_found && req.req_valid[k]) begin
        win       = PTR_W'(k);
        win_found = 1'b1;
      end
    end
  end

  assign win_op   = req.req_op[win];
  assign win_idx  = req.req_idx[32'(win)*IDX_W +: IDX_W];
  assign win_mask = {{(N_BITS-1){1'b0}}, 1'b1} << win_idx;
  assign win_oob  = 32'(win_idx) >= N_BITS;
  assign win_next = (32'(win) == N_REQ - 1) ? '0 : win + 1'b1;

`ifdef SR_SCHED_NOP_FILTER_EN
  assign win_nop = (win_op == |(q_shadow & win_mask));
`else
  assign win_nop = 1'b0;
`endif

  assign req.req_ready = (state == IDLE && win_found)
                         ? ({{(N_REQ-1){1'b0}}, 1'b1} << win) : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      ptr      <= '0;
      nxt_q    <= '0;
      cnt      <= '0;
      op_q     <= 1'b0;
      mask_q   <= '0;
      s_out    <= '0;
      r_out    <= '0;
      q_shadow <= '0;
      busy     <= 1'b0;
      err_idx  <= 1'b0;
    end else begin
      err_idx <= 1'b0;
      case (state)
        IDLE: begin
          // In IDLE a winner always sees ready, so win_found is the transfer.
          if (win_found) begin
            if (win_oob) begin
              err_idx <= 1'b1;
              ptr     <= win_next;
            end else if (win_nop) begin
              ptr <= win_next;
            end else begin
              state  <= DRIVE;
              busy   <= 1'b1;
              op_q   <= win_op;
              mask_q <= win_mask;
              nxt_q  <= win_next;
              cnt    <= CNT_W'(PULSE_CYC - 1);
              s_out  <= win_op ? win_mask : '0;
              r_out  <= win_op ? '0 : win_mask;
            end
          end
        end
        DRIVE: begin
          if (cnt == '0) begin
            state    <= IDLE;
            busy     <= 1'b0;
            s_out    <= '0;
            r_out    <= '0;
            ptr      <= nxt_q;
            q_shadow <= op_q ? (q_shadow | mask_q) : (q_shadow & ~mask_q);
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
